// File: rtl/image_frame_rx.sv
// Receive side of the image packet link: parses sync/header, emits
// pixels with coordinates, and verifies the trailing mod-256 checksum.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   in_valid      in_data carries a stream byte this cycle
//   in_data       stream byte
//   pix_valid     pix_data/pix_col/pix_row valid this cycle
//   pix_data      pixel byte
//   pix_col       0-based column of the pixel
//   pix_row       0-based row of the pixel
//   sof/eol/eof   first pixel of frame / last of row / last of frame
//   frame_done    pulse after the checksum byte is consumed
//   chk_ok        checksum match, held until the next frame's sof
//   err_hdr       pulse when a header fails the range check
//   busy          receiver is inside a frame (not IDLE)
module image_frame_rx #(
    parameter int          MAX_WIDTH  = 346,
    parameter int          MAX_HEIGHT = 371,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          pix_valid,
    output logic [7:0]                    pix_data,
    output logic [$clog2(MAX_WIDTH)-1:0]  pix_col,
    output logic [$clog2(MAX_HEIGHT)-1:0] pix_row,
    output logic                          sof,
    output logic                          eol,
    output logic                          eof,
    output logic                          frame_done,
    output logic                          chk_ok,
    output logic                          err_hdr,
    output logic                          busy
);

    localparam int CW = $clog2(MAX_WIDTH);
    localparam int RW = $clog2(MAX_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PIX,
        S_CHK
    } state_t;

    state_t        state;
    state_t        state_d;

    logic [1:0]    hdr_idx;
    logic [15:0]   w;
    logic [15:0]   h;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    acc;

    logic [15:0]   h_full;
    logic          hdr_bad;
    logic          last_col;
    logic          last_row;

    logic          pix_valid_d;
    logic [7:0]    pix_data_d;
    logic [CW-1:0] pix_col_d;
    logic [RW-1:0] pix_row_d;
    logic          sof_d;
    logic          eol_d;
    logic          eof_d;
    logic          frame_done_d;
    logic          chk_ok_d;
    logic          err_hdr_d;

    // The 4th header byte is still on in_data when the range check runs.
    assign h_full  = {in_data, h[7:0]};
    assign hdr_bad = (w == 16'd0) || (h_full == 16'd0) ||
                     (w > 16'(MAX_WIDTH)) ||
                     (h_full > 16'(MAX_HEIGHT));

    assign last_col = (16'(col) == w - 16'd1);
    assign last_row = (16'(row) == h - 16'd1);

    assign busy = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (in_valid) begin
            unique case (state)
                S_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    if (hdr_idx == 2'd3) begin
                        state_d = hdr_bad ? S_IDLE : S_PIX;
                    end
                end
                S_PIX: begin
                    if (last_col && last_row) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data;
        pix_col_d    = pix_col;
        pix_row_d    = pix_row;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        eof_d        = 1'b0;
        frame_done_d = 1'b0;
        chk_ok_d     = chk_ok;
        err_hdr_d    = 1'b0;
        if (in_valid) begin
            unique case (state)
                S_IDLE: begin
                end
                S_HDR: begin
                    if (hdr_idx == 2'd3 && hdr_bad) begin
                        err_hdr_d = 1'b1;
                    end
                end
                S_PIX: begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = in_data;
                    pix_col_d   = col;
                    pix_row_d   = row;
                    sof_d       = (col == '0) && (row == '0);
                    eol_d       = last_col;
                    eof_d       = last_col && last_row;
                    // Previous frame's result is retired at the new sof.
                    if ((col == '0) && (row == '0)) begin
                        chk_ok_d = 1'b0;
                    end
                end
                S_CHK: begin
                    frame_done_d = 1'b1;
                    chk_ok_d     = (in_data == acc);
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_col    <= '0;
            pix_row    <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            frame_done <= 1'b0;
            chk_ok     <= 1'b0;
            err_hdr    <= 1'b0;
        end else begin
            pix_valid  <= pix_valid_d;
            pix_data   <= pix_data_d;
            pix_col    <= pix_col_d;
            pix_row    <= pix_row_d;
            sof        <= sof_d;
            eol        <= eol_d;
            eof        <= eof_d;
            frame_done <= frame_done_d;
            chk_ok     <= chk_ok_d;
            err_hdr    <= err_hdr_d;
        end
    end

    // Header capture, pixel coordinates and checksum accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_idx <= '0;
            w       <= '0;
            h       <= '0;
            col     <= '0;
            row     <= '0;
            acc     <= '0;
        end else if (in_valid) begin
            unique case (state)
                S_IDLE: begin
                    hdr_idx <= '0;
                end
                S_HDR: begin
                    hdr_idx <= hdr_idx + 2'd1;
                    unique case (hdr_idx)
                        2'd0: w[7:0]  <= in_data;
                        2'd1: w[15:8] <= in_data;
                        2'd2: h[7:0]  <= in_data;
                        2'd3: begin
                            h[15:8] <= in_data;
                            col     <= '0;
                            row     <= '0;
                            acc     <= '0;
                        end
                    endcase
                end
                S_PIX: begin
                    acc <= acc + in_data;
                    if (last_col) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                S_CHK: begin
                end
            endcase
        end
    end

endmodule

// File: doc/image_frame_rx.md
# image_frame_rx

Receive-side stage that consumes the byte stream produced by the image packet source: one byte per strobe cycle, framed as sync, header, pixels, checksum. It parses and range-checks the header, emits each pixel with its row and column coordinates, and computes a running mod-256 checksum of the pixel bytes. It compares that sum with the trailing checksum byte and reports frame completion and integrity status to the downstream image buffer and status logic.

## Interface
Parameters:
- MAX_WIDTH, 346, largest accepted frame width in pixels.
- MAX_HEIGHT, 371, largest accepted frame height in pixels.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  in_data carries a byte this cycle.
- in_data  in  8  stream byte.
- pix_valid  out  1  pix_data/pix_col/pix_row valid this cycle.
- pix_data  out  8  pixel byte.
- pix_col  out  $clog2(MAX_WIDTH)  column, 0-based.
- pix_row  out  $clog2(MAX_HEIGHT)  row, 0-based.
- sof  out  1  with first pixel of a frame.
- eol  out  1  with last pixel of each row.
- eof  out  1  with last pixel of the frame.
- frame_done  out  1  one-cycle pulse after checksum byte consumed.
- chk_ok  out  1  checksum result; valid from frame_done until next sof.
- err_hdr  out  1  one-cycle pulse on rejected header.
- busy  out  1  high in any state other than IDLE.

## Operation
- Frame format, byte order: SYNC_BYTE; W[7:0]; W[15:8]; H[7:0]; H[15:8]; W*H pixels, row-major; checksum = (sum of pixel bytes) mod 256.
- A byte is consumed only when in_valid=1. Idle cycles (in_valid=0) are allowed anywhere; they hold all state and produce no output pulses.
- States:
  - IDLE: bytes other than SYNC_BYTE are discarded. SYNC_BYTE -> HDR, header index 0.
  - HDR: captures 4 bytes. After the 4th byte:
    - if W==0, H==0, W>MAX_WIDTH or H>MAX_HEIGHT: err_hdr pulse, -> IDLE;
    - otherwise clear col/row/accumulator, -> PIX.
  - PIX: each byte is output as a pixel and added to the 8-bit accumulator, which wraps with no carry out. col increments; at col==W-1, col clears and row increments. The byte at (W-1, H-1) -> CHK.
  - CHK: next byte is compared with the accumulator. chk_ok <= (equal), frame_done pulse, -> IDLE.
- SYNC_BYTE inside HDR/PIX/CHK is ordinary data; there is no resynchronisation mid-frame.
- Header fields are 16 bits wide; the range check uses the full 16-bit value.
- chk_ok clears to 0 on the sof of the next frame.
- Reset (any state, including mid-frame): abandon the frame, -> IDLE. All outputs and counters go to 0.

## Timing
- Reset values: all outputs 0, state IDLE.
- Pixel latency: 1 cycle. The byte accepted at edge N appears on pix_* with pix_valid=1 after edge N, i.e. during cycle N+1.
- sof, eol and eof are coincident with the pix_valid of the qualifying pixel. For a 1-pixel-wide frame, eol is set on every pixel. For a 1x1 frame, sof, eol and eof are all set on the same pixel.
- err_hdr: 1 cycle after the 4th header byte is accepted.
- frame_done and chk_ok update: 1 cycle after the checksum byte is accepted.
- Back-to-back frames: SYNC_BYTE may arrive on the cycle immediately after the checksum byte and is accepted, because the state is IDLE by then.
- busy: goes high the cycle after SYNC_BYTE is accepted. Returns low in the same cycle frame_done or err_hdr pulses.
- No backpressure; the block accepts every valid byte.

## Test plan
- 2x2 frame A5 02 00 02 00 01 02 03 04 0A -> four pix_valid with (col,row) = (0,0),(1,0),(0,1),(1,1); sof on first; eol on 2nd and 4th; eof on 4th; frame_done=1 with chk_ok=1.
- Wrap: 2x1 frame, pixels FF FF, checksum FE -> chk_ok=1. Same frame with checksum FF -> chk_ok=0, frame_done=1.
- Header reject: A5 5B 01 01 00 (W=347) -> err_hdr pulse, no pix_valid. A following valid 1x1 frame A5 01 00 01 00 7E 7E -> sof, eol and eof together, chk_ok=1.
- Gaps and junk: leading bytes 00 FF 12, then a 2x2 frame with in_valid toggling 1/0 every cycle -> same pixel, coordinate and checksum results as the first scenario.
- Back-to-back: two 2x2 frames with no idle cycle between them -> two frame_done pulses. chk_ok drops at the second sof.
- Reset mid-frame: assert rst=0 after the 2nd pixel, release, send a full 2x2 frame -> outputs 0 during reset; the new frame is received correctly with chk_ok=1.
